mult_seq_ctrl: RTL and testbench

Sequencing controller for the calculator's iterative shift-add multiplier on the fast multiplier clock. It accepts one multiply request at a time from the slow-clock CPU datapath through a start/done handshake and latches the operands. It steps a radix-2 accumulate/shift datapath for exactly WIDTH iterations, with a zero-operand early-out. It holds the 2*WIDTH-bit product until the next accepted request.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_step.sv | 26 ++
 rtl/mult_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned MULT_WIDTH = 32;

    // Iteration counter width; counts 0..WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration: conditional add into the upper half, then shift right.
module mult_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next_c,
    output logic [WIDTH-1:0] mplier_next_c
);

    logic [WIDTH:0] sum;

    // The carry lands in the accumulator MSB; the accumulator LSB moves into the multiplier.
    always_comb begin
        sum = {1'b0, acc};
        if (mplier[0]) begin
            sum = {1'b0, acc} + {1'b0, mcand};
        end
        acc_next_c    = sum[WIDTH:1];
        mplier_next_c = {sum[0], mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the iterative shift-add multiplier (start/done handshake).
// Optional two's-complement support is built when MULT_SIGNED_EN is defined.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk1,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
`ifdef MULT_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W  = cnt_width(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               signed_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               signed_req;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               negate;
    logic               zero_op;
    logic               last_iter;
    logic [WIDTH-1:0]   acc_next_c;
    logic [WIDTH-1:0]   mplier_next_c;
    logic [PROD_W-1:0]  step_prod;
    logic [PROD_W-1:0]  result;

`ifdef MULT_SIGNED_EN
    assign signed_req = is_signed;
`else
    assign signed_req = 1'b0;
`endif

    // Most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign mag_a     = (signed_q && a_q[WIDTH-1]) ? (-a_q) : a_q;
    assign mag_b     = (signed_q && b_q[WIDTH-1]) ? (-b_q) : b_q;
    assign negate    = signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign zero_op   = (a_q == '0) || (b_q == '0);
    assign last_iter = (cnt_q == LAST_ITER);
    assign step_prod = {acc_next_c, mplier_next_c};
    assign result    = negate ? (-step_prod) : step_prod;

    mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mcand         (mcand_q),
        .acc           (acc_q),
        .mplier        (mplier_q),
        .acc_next_c    (acc_next_c),
        .mplier_next_c (mplier_next_c)
    );

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; flush overrides every transition, including a start in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = zero_op ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy <= (state_next == LOAD) || (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        signed_q <= signed_req;
                    end
                end
                LOAD: begin
                    acc_q    <= '0;
                    mcand_q  <= mag_a;
                    mplier_q <= mag_b;
                    cnt_q    <= '0;
                    if (zero_op && !flush) begin
                        product <= '0;
                    end
                end
                RUN: begin
                    acc_q    <= acc_next_c;
                    mplier_q <= mplier_next_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter && !flush) begin
                        product <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl; signed cases run only when MULT_SIGNED_EN is defined.
module tb_mult_seq_ctrl;

    localparam int unsigned W = 32;

    logic             clk1;
    logic             reset;
    logic             start;
    logic             flush;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
`ifdef MULT_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int               errors;
    int               checks;
    logic [2*W-1:0]   exp_q[$];
    logic [2*W-1:0]   last_prod;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef MULT_SIGNED_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic signed [2*W-1:0] sp;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            sp = sa * sb;
            return sp;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Launch one request, track busy/done per edge, then check latency and product.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int pulse_n);
        int             n;
        int             lat;
        logic           seen;
        logic           busy_ok;
        logic [2*W-1:0] exp_p;
        lat = ((a == '0) || (b == '0)) ? 2 : int'(W) + 2;
        exp_q.push_back(model(a, b, s));
        @(posedge clk1); #1;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
`ifdef MULT_SIGNED_EN
        is_signed = s;
`endif
        @(posedge clk1); #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk1);
            n++;
            start = (n == pulse_n);
            if (n == pulse_n) begin
                op_a = ~a;
                op_b = ~b;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== (n < lat)) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || n != lat) begin
            errors++;
            $display("FAIL latency a=%h b=%h: done at edge %0d (seen=%0b), required %0d", a, b, n, seen, lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_window a=%h b=%h: busy wrong within E1..E%0d", a, b, lat);
        end
        exp_p = exp_q.pop_front();
        checks++;
        if (product !== exp_p) begin
            errors++;
            $display("FAIL product a=%h b=%h s=%0b: got %h, required %h", a, b, s, product, exp_p);
        end
        last_prod = exp_p;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk1);
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b, required both 0", name, busy, done);
        end
        checks++;
        if (product !== last_prod) begin
            errors++;
            $display("FAIL %s_product: got %h, required %h", name, product, last_prod);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef MULT_SIGNED_EN
        is_signed = 1'b0;
`endif
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        reset = 1'b1;
        last_prod = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk1);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: busy=%0b done=%0b product=%h, required 0/0/0",
                         i, busy, done, product);
            end
        end
    endtask

    task automatic test_unsigned();
        run_op(32'd7, 32'd6, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op(32'h0, 32'h1234, 1'b0, -1);
        run_op(32'h1, 32'h8000_0000, 1'b0, -1);
        run_op(32'hDEAD_BEEF, 32'h0, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            b = $urandom();
            if (i == 4) a = '0;
            run_op(a, b, 1'b0, -1);
        end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, -1);
        run_op(32'h0, 32'hFFFF_FFFF, 1'b1, -1);
    endtask
`endif

    task automatic test_start_ignored();
        run_op(32'd11, 32'd13, 1'b0, 5);
        expect_quiet("single_done", 40);
    endtask

    task automatic test_flush();
        @(posedge clk1); #1;
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk1);
            flush = (n == 10);
        end
        @(negedge clk1);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_to_idle: busy=%0b done=%0b, required 0/0", busy, done);
        end
        expect_quiet("flush_no_done", 40);
        @(posedge clk1); #1;
        op_a  = 32'd3;
        op_b  = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        flush = 1'b0;
        expect_quiet("flush_start", 40);
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk1); #1;
        op_a  = 32'h1234;
        op_b  = 32'h5678;
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (19) @(posedge clk1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%0b done=%0b product=%h, required 0/0/0",
                     busy, done, product);
        end
        @(negedge clk1);
        reset = 1'b1;
        last_prod = '0;
        run_op(32'd2, 32'd3, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_op(32'h0001_0001, 32'h0001_0001, 1'b0, -1);
        run_op(32'h0, 32'h0, 1'b0, -1);
        run_op(32'h7FFF_FFFF, 32'h2, 1'b0, -1);
    endtask

    initial begin
        clk1   = 1'b0;
        errors = 0;
        checks = 0;
        test_reset();
        test_unsigned();
        test_back_to_back();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_start_ignored();
        test_flush();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
